// File: rtl/interrupt_ctrl_if.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl_if
//   Memory-stage word bus into the interrupt controller's register window.
//   The core side (master) issues word stores and addresses. The controller
//   side (slave) returns combinational load data and an address-hit flag.
//
//   bus_we     master->slave  store strobe, word access only
//   bus_addr   master->slave  byte address
//   bus_wdata  master->slave  store data
//   bus_rdata  slave->master  load data, 0 when bus_hit is low
//   bus_hit    slave->master  bus_addr falls inside the register window
// -----------------------------------------------------------------------------
interface interrupt_ctrl_if;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_hit;

  modport master (
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_hit
  );

  modport slave (
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_hit
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl
//   Machine-level interrupt source block feeding the exception/CSR stage.
//   It contains three interrupt sources:
//     - a 64-bit mtime/mtimecmp timer, memory mapped,
//     - a software interrupt bit (msip),
//     - an external IRQ line that is synchronised and rising-edge detected.
//   Pending sources are masked by mie and mstatus.MIE. The block selects the
//   highest-priority source and holds a request/ack handshake until the trap
//   has been taken and the handler has returned with mret.
//
// Parameters
//   BASE_ADDR  byte address of the 5-word register window
//   PRESCALE   clk cycles per mtime increment (>= 1)
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   bus            slave side of the memory-stage word bus
//   ext_irq_async  asynchronous external interrupt line, rising-edge triggered
//   mstatus_mie    global machine interrupt enable
//   mie            CSR mie; bits 3 (MSIE), 7 (MTIE) and 11 (MEIE) are used
//   int_ack        one-cycle pulse when the exception stage takes the request
//   mret           one-cycle pulse when mret retires
//   interrupt      registered level request to the exception stage
//   int_cause      mcause value for the current request
//   mip            pending bits: [3] MSIP, [7] MTIP, [11] MEIP
//
// Register window (word offsets from BASE_ADDR)
//   0x00 mtime_lo   0x04 mtime_hi   0x08 mtimecmp_lo   0x0C mtimecmp_hi
//   0x10 msip (only bit 0 is stored; the other bits read as 0)
// -----------------------------------------------------------------------------
module interrupt_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  interrupt_ctrl_if.slave        bus,
  input  logic                   ext_irq_async,
  input  logic                   mstatus_mie,
  input  logic [31:0]            mie,
  input  logic                   int_ack,
  input  logic                   mret,
  output logic                   interrupt,
  output logic [31:0]            int_cause,
  output logic [31:0]            mip
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int unsigned CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  // Word indices within the register window (byte offset >> 2).
  localparam logic [2:0] W_MTIME_LO = 3'd0;
  localparam logic [2:0] W_MTIME_HI = 3'd1;
  localparam logic [2:0] W_CMP_LO   = 3'd2;
  localparam logic [2:0] W_CMP_HI   = 3'd3;
  localparam logic [2:0] W_MSIP     = 3'd4;

  localparam logic [31:0] WINDOW_BYTES = 32'h0000_0014;

  // Handshake FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;

  // Machine interrupt cause codes.
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [63:0]      mtime_q,       mtime_d;
  logic [63:0]      mtimecmp_q,    mtimecmp_d;
  logic             msip_q,        msip_d;
  logic [CNT_W-1:0] presc_cnt_q,   presc_cnt_d;
  logic             sync1_q,       sync1_d;
  logic             sync2_q,       sync2_d;
  logic             sync_prev_q,   sync_prev_d;
  logic             meip_q,        meip_d;
  logic             mtip_q,        mtip_d;
  logic [1:0]       state_q,       state_d;
  logic             interrupt_q,   interrupt_d;
  logic [31:0]      int_cause_q,   int_cause_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // Subtract the base once. Addresses below BASE_ADDR wrap to large offsets,
  // so a single unsigned compare covers both ends of the window.
  logic [31:0] offset;
  logic [2:0]  word_sel;
  logic        wr_en;

  assign offset      = bus.bus_addr - BASE_ADDR;
  assign bus.bus_hit = (offset < WINDOW_BYTES);
  assign word_sel    = offset[4:2];
  assign wr_en       = bus.bus_we & bus.bus_hit;

  // ---------------------------------------------------------------------------
  // Source status and selection
  // ---------------------------------------------------------------------------
  logic        ext_edge;
  logic [31:0] mip_vec;
  logic [31:0] en;
  logic [3:0]  sel_code;

  // The edge detector looks at the second synchroniser stage against its own
  // delayed copy, so the input is never sampled before it is metastable-safe.
  assign ext_edge = sync2_q & ~sync_prev_q;

  assign mip_vec = {20'b0, meip_q, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};
  assign en      = mip_vec & mie & {32{mstatus_mie}};

  // Fixed priority: external > software > timer.
  always_comb begin
    sel_code = 4'd0;
    if (en[11])     sel_code = CODE_MEI;
    else if (en[3]) sel_code = CODE_MSI;
    else if (en[7]) sel_code = CODE_MTI;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through this block
    // can leave a variable unassigned and infer a latch.
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    presc_cnt_d = presc_cnt_q;
    meip_d      = meip_q;
    state_d     = state_q;
    int_cause_d = int_cause_q;

    // Timer prescaler and increment. mtime wraps silently at 2^64.
    if (presc_cnt_q == CNT_MAX) begin
      presc_cnt_d = '0;
      mtime_d     = mtime_q + 64'd1;
    end else begin
      presc_cnt_d = presc_cnt_q + CNT_W'(1);
    end

    // Register writes. A write to either mtime half overrides the whole
    // increment of this cycle, and it also restarts the prescale count. As a
    // result, software sees exactly the value it wrote for a full period.
    if (wr_en) begin
      case (word_sel)
        W_MTIME_LO: begin
          mtime_d     = {mtime_q[63:32], bus.bus_wdata};
          presc_cnt_d = '0;
        end
        W_MTIME_HI: begin
          mtime_d     = {bus.bus_wdata, mtime_q[31:0]};
          presc_cnt_d = '0;
        end
        W_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus.bus_wdata};
        W_CMP_HI: mtimecmp_d = {bus.bus_wdata, mtimecmp_q[31:0]};
        W_MSIP:   msip_d     = bus.bus_wdata[0];
        default:  ;
      endcase
    end

    // Timer pending is a pure registered compare of the current values, so it
    // follows any mtime/mtimecmp change one cycle later.
    mtip_d = (mtime_q >= mtimecmp_q);

    // Two-flop synchroniser plus the delayed copy for edge detection.
    sync1_d     = ext_irq_async;
    sync2_d     = sync1_q;
    sync_prev_d = sync2_q;

    // Handshake FSM.
    case (state_q)
      ST_IDLE: begin
        if (en != 32'd0) begin
          state_d     = ST_REQ;
          int_cause_d = {1'b1, 27'b0, sel_code};
        end
      end
      ST_REQ: begin
        // The ack takes precedence over a same-cycle mask. Once the exception
        // stage has taken the trap, the request must not be withdrawn.
        if (int_ack) begin
          state_d = ST_SVC;
          if (int_cause_q[3:0] == CODE_MEI) meip_d = 1'b0;
        end else if (en == 32'd0) begin
          state_d = ST_IDLE;
        end
      end
      ST_SVC: begin
        if (mret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge overrides the ack-clear above, so an IRQ that arrives while
    // the previous one is being acknowledged is not lost.
    if (ext_edge) meip_d = 1'b1;

    // The request output is registered and mirrors the next state, so it is
    // high exactly while the FSM sits in REQ.
    interrupt_d = (state_d == ST_REQ);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      presc_cnt_q <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
      meip_q      <= 1'b0;
      mtip_q      <= 1'b0;
      state_q     <= ST_IDLE;
      interrupt_q <= 1'b0;
      int_cause_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments, so every flop here samples the values
      // from before the edge and the synchroniser chain shifts one stage per cycle.
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      presc_cnt_q <= presc_cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_prev_q <= sync_prev_d;
      meip_q      <= meip_d;
      mtip_q      <= mtip_d;
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
      int_cause_q <= int_cause_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign interrupt = interrupt_q;
  assign int_cause = int_cause_q;
  assign mip       = mip_vec;

  // Load data is combinational from the registers. No lo/hi snapshot is
  // taken, so software re-reads mtime_hi to detect a carry between halves.
  always_comb begin
    bus.bus_rdata = 32'd0;
    if (bus.bus_hit) begin
      case (word_sel)
        W_MTIME_LO: bus.bus_rdata = mtime_q[31:0];
        W_MTIME_HI: bus.bus_rdata = mtime_q[63:32];
        W_CMP_LO:   bus.bus_rdata = mtimecmp_q[31:0];
        W_CMP_HI:   bus.bus_rdata = mtimecmp_q[63:32];
        W_MSIP:     bus.bus_rdata = {31'b0, msip_q};
        default:    bus.bus_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interrupt_ctrl
//   Directed bench for interrupt_ctrl. The main instance uses PRESCALE=1 and
//   carries the handshake scenarios. A second instance uses PRESCALE=3 and is
//   used only to observe prescaler restart after an mtime write.
//   Each step below notes the clock edge it lands on, counted from reset release.
// -----------------------------------------------------------------------------
module tb_interrupt_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  localparam logic [4:0] O_MTIME_LO = 5'h00;
  localparam logic [4:0] O_MTIME_HI = 5'h04;
  localparam logic [4:0] O_CMP_LO   = 5'h08;
  localparam logic [4:0] O_CMP_HI   = 5'h0C;
  localparam logic [4:0] O_MSIP     = 5'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_irq_async;
  logic        mstatus_mie;
  logic [31:0] mie;
  logic        int_ack;
  logic        mret;
  logic        interrupt;
  logic [31:0] int_cause;
  logic [31:0] mip;

  logic        interrupt3;
  logic [31:0] int_cause3;
  logic [31:0] mip3;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  interrupt_ctrl_if bus  ();
  interrupt_ctrl_if bus3 ();

  interrupt_ctrl #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .ext_irq_async (ext_irq_async),
    .mstatus_mie   (mstatus_mie),
    .mie           (mie),
    .int_ack       (int_ack),
    .mret          (mret),
    .interrupt     (interrupt),
    .int_cause     (int_cause),
    .mip           (mip)
  );

  interrupt_ctrl #(.BASE_ADDR(BASE), .PRESCALE(3)) dut3 (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus3),
    .ext_irq_async (1'b0),
    .mstatus_mie   (1'b0),
    .mie           (32'd0),
    .int_ack       (1'b0),
    .mret          (1'b0),
    .interrupt     (interrupt3),
    .int_cause     (int_cause3),
    .mip           (mip3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
    bus.bus_addr  = BASE + {27'd0, off};
    bus.bus_wdata = data;
    bus.bus_we    = 1'b1;
    tick();
    bus.bus_we    = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] off, input logic [31:0] exp);
    bus.bus_addr = BASE + {27'd0, off};
    #1;
    check(tag, bus.bus_rdata, exp);
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    ext_irq_async  = 1'b0;
    mstatus_mie    = 1'b1;
    mie            = 32'h0000_0080;
    int_ack        = 1'b0;
    mret           = 1'b0;
    bus.bus_we     = 1'b0;
    bus.bus_addr   = BASE;
    bus.bus_wdata  = 32'd0;
    bus3.bus_we    = 1'b0;
    bus3.bus_addr  = BASE;
    bus3.bus_wdata = 32'd0;

    // ---- Reset state -------------------------------------------------------
    tick();
    tick();
    check1("rst_interrupt", interrupt, 1'b0);
    check ("rst_cause",     int_cause, 32'd0);
    check ("rst_mip",       mip,       32'd0);
    read_check("rst_cmp_lo",   O_CMP_LO,   32'hFFFF_FFFF);
    read_check("rst_cmp_hi",   O_CMP_HI,   32'hFFFF_FFFF);
    read_check("rst_mtime_lo", O_MTIME_LO, 32'd0);
    read_check("rst_msip",     O_MSIP,     32'd0);
    check1("hit_last_word", bus.bus_hit, 1'b1);
    bus.bus_addr = BASE + 32'h14;
    #1;
    check1("hit_past_end", bus.bus_hit, 1'b0);
    check ("rdata_past_end", bus.bus_rdata, 32'd0);
    bus.bus_addr = BASE - 32'h4;
    #1;
    check1("hit_below_base", bus.bus_hit, 1'b0);
    rst = 1'b1;

    // ---- 1. Timer interrupt: mtimecmp = 5 ---------------------------------
    bus_write(O_CMP_HI, 32'd0);              // E1: mtime 1
    bus_write(O_CMP_LO, 32'd5);              // E2: mtime 2
    read_check("mtime_after_release", O_MTIME_LO, 32'd2);
    read_check("cmp_lo_written",      O_CMP_LO,   32'd5);
    tick(); tick(); tick();                  // E5: compare saw mtime 4
    check("mip_before_match", mip, 32'd0);
    tick();                                  // E6: compare saw mtime 5
    check ("mip_timer", mip, 32'h0000_0080);
    check1("irq_not_yet", interrupt, 1'b0);
    tick();                                  // E7: IDLE -> REQ
    check1("irq_timer", interrupt, 1'b1);
    check ("cause_timer", int_cause, 32'h8000_0007);

    // ---- 3. Mask before ack, then re-enable --------------------------------
    mstatus_mie = 1'b0;
    tick();                                  // E8: REQ -> IDLE
    check1("irq_masked_drop", interrupt, 1'b0);
    mstatus_mie = 1'b1;
    tick();                                  // E9: IDLE -> REQ
    check1("irq_rerequest", interrupt, 1'b1);
    check ("cause_rerequest", int_cause, 32'h8000_0007);

    // ---- 4. Ack, hold off until mret ---------------------------------------
    int_ack = 1'b1;
    tick();                                  // E10: REQ -> SVC
    int_ack = 1'b0;
    check1("irq_after_ack", interrupt, 1'b0);
    int_ack = 1'b1;
    tick();                                  // E11: ack in SVC is ignored
    int_ack = 1'b0;
    tick();                                  // E12
    check1("irq_svc_blocked", interrupt, 1'b0);
    check ("mip_svc_timer", mip, 32'h0000_0080);
    mret = 1'b1;
    tick();                                  // E13: SVC -> IDLE
    mret = 1'b0;
    check1("irq_mret_cycle", interrupt, 1'b0);
    tick();                                  // E14: IDLE -> REQ
    check1("irq_after_mret", interrupt, 1'b1);
    mret = 1'b1;
    tick();                                  // E15: mret in REQ is ignored
    mret = 1'b0;
    check1("irq_mret_in_req", interrupt, 1'b1);

    // ---- 2a. External edge while in REQ: cause held, then priority ----------
    mie           = 32'h0000_0888;
    ext_irq_async = 1'b1;
    tick();                                  // E16: sync1
    ext_irq_async = 1'b0;
    tick();                                  // E17: sync2
    tick();                                  // E18: MEIP latched
    check("mip_ext_and_timer", mip, 32'h0000_0880);
    check("cause_held_in_req", int_cause, 32'h8000_0007);
    int_ack = 1'b1;
    tick();                                  // E19: ack timer request
    int_ack = 1'b0;
    check ("mip_meip_kept_on_mti_ack", mip, 32'h0000_0880);
    mret = 1'b1;
    tick();                                  // E20: SVC -> IDLE
    mret = 1'b0;
    tick();                                  // E21: REQ with MEI
    check1("irq_ext", interrupt, 1'b1);
    check ("cause_ext_priority", int_cause, 32'h8000_000B);
    int_ack = 1'b1;
    tick();                                  // E22: ack clears MEIP
    int_ack = 1'b0;
    check ("mip_meip_cleared", mip, 32'h0000_0080);
    check1("irq_ext_acked", interrupt, 1'b0);

    // ---- 2b. External latency from IDLE ------------------------------------
    mie  = 32'h0000_0800;
    mret = 1'b1;
    tick();                                  // E23: SVC -> IDLE, timer masked
    mret = 1'b0;
    check1("irq_idle_masked", interrupt, 1'b0);
    ext_irq_async = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n++;
      ext_irq_async = 1'b0;
      if (interrupt) break;
    end
    check1("ext_latency_within_4", (interrupt === 1'b1) && (n <= 4), 1'b1);
    check ("cause_ext_idle", int_cause, 32'h8000_000B);
    check ("mip_ext_idle",   mip,       32'h0000_0880);

    // ---- 2c. Edge in the same cycle as the MEI ack keeps MEIP --------------
    ext_irq_async = 1'b1;
    tick();                                  // sync1
    ext_irq_async = 1'b0;
    tick();                                  // sync2: edge visible this cycle
    int_ack = 1'b1;
    tick();                                  // ack and set on the same edge
    int_ack = 1'b0;
    check1("irq_set_wins_ack", interrupt, 1'b0);
    check ("mip_set_wins", mip, 32'h0000_0880);

    // ---- Software interrupt: MSI beats MTI ---------------------------------
    bus_write(O_MSIP, 32'hFFFF_FFFF);
    read_check("msip_readback", O_MSIP, 32'd1);
    mie  = 32'h0000_0088;
    mret = 1'b1;
    tick();                                  // SVC -> IDLE
    mret = 1'b0;
    tick();                                  // IDLE -> REQ
    check1("irq_msi", interrupt, 1'b1);
    check ("cause_msi", int_cause, 32'h8000_0003);
    check ("mip_all", mip, 32'h0000_0888);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check ("mip_after_msi_ack", mip, 32'h0000_0888);

    // ---- 5. mtime write overrides increment, and mtime wraps ---------------
    bus_write(O_MTIME_LO, 32'h10);
    read_check("mtime_write_wins", O_MTIME_LO, 32'h10);
    read_check("mtime_hi_untouched", O_MTIME_HI, 32'd0);
    tick();
    read_check("mtime_next", O_MTIME_LO, 32'h11);
    bus_write(O_MTIME_LO, 32'hFFFF_FFFF);
    bus_write(O_MTIME_HI, 32'hFFFF_FFFF);
    read_check("mtime_max_lo", O_MTIME_LO, 32'hFFFF_FFFF);
    read_check("mtime_max_hi", O_MTIME_HI, 32'hFFFF_FFFF);
    tick();
    read_check("mtime_wrap_lo", O_MTIME_LO, 32'd0);
    read_check("mtime_wrap_hi", O_MTIME_HI, 32'd0);

    // ---- Prescaler restart (PRESCALE=3 instance) ---------------------------
    bus3.bus_addr  = BASE;
    bus3.bus_wdata = 32'h10;
    bus3.bus_we    = 1'b1;
    tick();                                  // W: count restarts at 0
    bus3.bus_we    = 1'b0;
    check("p3_write", bus3.bus_rdata, 32'h10);
    tick();
    check("p3_hold1", bus3.bus_rdata, 32'h10);
    tick();
    check("p3_hold2", bus3.bus_rdata, 32'h10);
    tick();
    check("p3_incr", bus3.bus_rdata, 32'h11);

    // ---- 6. Asynchronous reset while in REQ --------------------------------
    mret = 1'b1;
    tick();                                  // SVC -> IDLE
    mret = 1'b0;
    tick();                                  // IDLE -> REQ (MSI)
    check1("irq_before_reset", interrupt, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check1("async_rst_interrupt", interrupt, 1'b0);
    check ("async_rst_cause",     int_cause, 32'd0);
    check ("async_rst_mip",       mip,       32'd0);
    read_check("async_rst_cmp_lo",   O_CMP_LO,   32'hFFFF_FFFF);
    read_check("async_rst_msip",     O_MSIP,     32'd0);
    read_check("async_rst_mtime_lo", O_MTIME_LO, 32'd0);
    rst = 1'b1;
    tick();
    check1("irq_after_reset_release", interrupt, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
